// File: rtl/interp_pkg.sv
// Shared types and the 16-phase, 8-tap interpolation coefficient table.
// Every phase row sums to 64 and the sum of |c| per phase stays below 128.
package interp_pkg;

  localparam int TAPS       = 8;
  localparam int NUM_PHASES = 16;

  typedef logic [3:0]        phase_t;
  typedef logic signed [7:0] coef_t;

  localparam coef_t COEF [NUM_PHASES][TAPS] = '{
    '{ 0,  0,   0, 64,  0,   0,  0,  0},
    '{ 0,  1,  -3, 63,  4,  -2,  1,  0},
    '{-1,  2,  -5, 62,  8,  -3,  1,  0},
    '{-1,  3,  -8, 60, 13,  -4,  1,  0},
    '{-1,  4, -10, 58, 17,  -5,  1,  0},
    '{-1,  4, -11, 52, 26,  -8,  3, -1},
    '{-1,  3,  -9, 47, 31, -10,  4, -1},
    '{-1,  4, -11, 45, 34, -10,  4, -1},
    '{-1,  4, -11, 40, 40, -11,  4, -1},
    '{-1,  4, -10, 34, 45, -11,  4, -1},
    '{-1,  4, -10, 31, 47,  -9,  3, -1},
    '{-1,  3,  -8, 26, 52, -11,  4, -1},
    '{ 0,  1,  -5, 17, 58, -10,  4, -1},
    '{ 0,  1,  -4, 13, 60,  -8,  3, -1},
    '{ 0,  1,  -3,  8, 62,  -5,  2, -1},
    '{ 0,  1,  -2,  4, 63,  -3,  1,  0}
  };

endpackage

// File: rtl/interp_mcm.sv
// Shift-add multiple-constant multiplier: one sample times the 8 coefficients
// of the selected phase, built from a small pool of shared shift/add terms.
module interp_mcm
  import interp_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic signed [IN_W-1:0]          sample,
  input  phase_t                          phase,
  output logic [TAPS-1:0][IN_W+7:0]       prod
);

  localparam int AW = IN_W + 8;

  logic signed [AW-1:0] x1, x2, x3, x4, x5, x6, x8, x10, x13, x15, x16, x32, x64;

  always_comb begin
    x1  = AW'(sample);
    x2  = x1 <<< 1;
    x4  = x1 <<< 2;
    x8  = x1 <<< 3;
    x16 = x1 <<< 4;
    x32 = x1 <<< 5;
    x64 = x1 <<< 6;
    x3  = x2 + x1;
    x5  = x4 + x1;
    x6  = x4 + x2;
    x10 = x8 + x2;
    x13 = x8 + x5;
    x15 = x16 - x1;
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    coef_t                c;
    logic [6:0]           mag;
    logic signed [AW-1:0] m;
    logic signed [AW-1:0] p;

    // Magnitude selects a shared constant product; sign is applied afterwards.
    always_comb begin
      c   = COEF[phase][gi];
      mag = c[7] ? 7'(-c) : c[6:0];
      case (mag)
        7'd1:    m = x1;
        7'd2:    m = x2;
        7'd3:    m = x3;
        7'd4:    m = x4;
        7'd5:    m = x5;
        7'd8:    m = x8;
        7'd9:    m = x8 + x1;
        7'd10:   m = x10;
        7'd11:   m = x8 + x3;
        7'd13:   m = x13;
        7'd17:   m = x16 + x1;
        7'd26:   m = x16 + x10;
        7'd31:   m = x32 - x1;
        7'd34:   m = x32 + x2;
        7'd40:   m = x32 + x8;
        7'd45:   m = x32 + x13;
        7'd47:   m = x32 + x15;
        7'd52:   m = x32 + x16 + x4;
        7'd58:   m = x64 - x6;
        7'd60:   m = x64 - x4;
        7'd62:   m = x64 - x2;
        7'd63:   m = x64 - x1;
        7'd64:   m = x64;
        default: m = '0;
      endcase
      p = c[7] ? -m : m;
    end

    assign prod[gi] = p;
  end

endmodule

// File: rtl/interp_fir_pipe.sv
// Streaming 8-tap transposed-form interpolation filter with valid/ready flow.
// Optional INTERP_SAT_EN: saturate the shifted result instead of wrapping it.
module interp_fir_pipe
  import interp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_sample,
  input  logic                    in_last,
  input  logic [3:0]              in_frac,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sample,
  output logic                    out_last
);

  localparam int AW = IN_W + 8;
  localparam int RW = AW + 1;

  typedef enum logic {IDLE, ROW} state_t;

  state_t     state_reg, state_next;
  logic [2:0] count_reg, count_next;
  phase_t     phase_reg, phase_next;

  logic   stall, accept, emit;
  phase_t mcm_phase;
  logic [TAPS-1:0][AW-1:0] prod;

  logic                    v1, emit1, last1;
  logic [TAPS-1:0][AW-1:0] prod_reg;
  logic signed [AW-1:0]    acc [TAPS-1];

  logic signed [AW-1:0]    full;
  logic signed [RW-1:0]    shifted;
  logic signed [OUT_W-1:0] narrowed;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  // The first sample of a row is filtered with the phase it brings along.
  assign mcm_phase = (state_reg == IDLE) ? in_frac : phase_reg;

  interp_mcm #(.IN_W(IN_W)) u_mcm (
    .sample (in_sample),
    .phase  (mcm_phase),
    .prod   (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      phase_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    phase_next = phase_reg;
    emit       = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!in_last) begin
            state_next = ROW;
            count_next = 3'd1;
            phase_next = in_frac;
          end
        end
        ROW: begin
          emit = (count_reg == 3'd7);
          if (in_last) begin
            state_next = IDLE;
            count_next = '0;
          end else if (count_reg != 3'd7) begin
            count_next = count_reg + 3'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      emit1    <= 1'b0;
      last1    <= 1'b0;
      prod_reg <= '0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        prod_reg <= prod;
        emit1    <= emit;
        last1    <= in_last;
      end
    end
  end

  assign full = acc[0] + $signed(prod_reg[TAPS-1]);

  // Transposed chain: acc[k] holds the partial sum of the output due k+1 samples later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS - 1; k++) acc[k] <= '0;
    end else if (!stall && v1) begin
      if (last1) begin
        for (int k = 0; k < TAPS - 1; k++) acc[k] <= '0;
      end else begin
        for (int k = 0; k < TAPS - 2; k++) acc[k] <= acc[k+1] + $signed(prod_reg[TAPS-2-k]);
        acc[TAPS-2] <= $signed(prod_reg[0]);
      end
    end
  end

  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(64'sd1 <<< (SHIFT - 1));
    logic signed [RW-1:0] rnd;
    always_comb begin
      rnd     = RW'(full) + HALF;
      shifted = rnd >>> SHIFT;
    end
  end else begin : g_noround
    assign shifted = RW'(full);
  end

`ifdef INTERP_SAT_EN
  if (OUT_W < RW) begin : g_sat
    localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);
    always_comb begin
      if (shifted > MAXV)      narrowed = {1'b0, {(OUT_W-1){1'b1}}};
      else if (shifted < MINV) narrowed = {1'b1, {(OUT_W-1){1'b0}}};
      else                     narrowed = OUT_W'(shifted);
    end
  end else begin : g_nosat
    assign narrowed = OUT_W'(shifted);
  end
`else
  assign narrowed = OUT_W'(shifted);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_last   <= 1'b0;
    end else if (!stall) begin
      out_valid <= v1 && emit1;
      if (v1 && emit1) begin
        out_sample <= narrowed;
        out_last   <= last1;
      end
    end
  end

endmodule
